// File: rtl/cv32e40x_pkg.sv
// cv32e40x_pkg: shared types, funct3 constants and multiply decode for the issue path
package cv32e40x_pkg;

    typedef enum logic [0:0] {
        MUL_M32 = 1'b0,
        MUL_H   = 1'b1
    } mul_opcode_e;

    typedef struct packed {
        mul_opcode_e operator;
        logic [1:0]  signed_mode;
        logic [31:0] op_a;
        logic [31:0] op_b;
    } mul_issue_entry_t;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;

    // signed_mode bit0 marks op_a signed, bit1 marks op_b signed
    function automatic mul_issue_entry_t mul_decode(input logic [2:0] funct3,
                                                    input logic [31:0] op_a,
                                                    input logic [31:0] op_b);
        mul_issue_entry_t e;
        e.operator    = (funct3 == FUNCT3_MUL) ? MUL_M32 : MUL_H;
        e.signed_mode = (funct3 == FUNCT3_MULH)   ? 2'b11 :
                        (funct3 == FUNCT3_MULHSU) ? 2'b01 : 2'b00;
        e.op_a        = op_a;
        e.op_b        = op_b;
        return e;
    endfunction

endpackage

// File: rtl/cv32e40x_mul_issue_fifo.sv
// cv32e40x_mul_issue_fifo: circular DEPTH-entry FIFO of issue entries with synchronous flush
module cv32e40x_mul_issue_fifo
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  mul_issue_entry_t wdata,
    output mul_issue_entry_t rdata,
    output logic [1:0]       count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    mul_issue_entry_t mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;

    // with DEPTH=1 the wrap compare always hits, pinning the pointers at 0
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= inc(wptr);
            end
            if (pop) rptr <= inc(rptr);
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/cv32e40x_mul_issue.sv
// cv32e40x_mul_issue: buffers decoded multiply instructions from ID and presents the
// head entry, held stable until popped, to the EX-stage multiplier.
module cv32e40x_mul_issue
    import cv32e40x_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  in_funct3_i,
    input  logic [31:0] in_op_a_i,
    input  logic [31:0] in_op_b_i,
    output logic        in_illegal_o,
    input  logic        halt_i,
    input  logic        kill_i,
    output logic        mul_valid_o,
    output mul_opcode_e mul_operator_o,
    output logic [1:0]  mul_signed_mode_o,
    output logic [31:0] mul_op_a_o,
    output logic [31:0] mul_op_b_o,
    output logic        mul_halt_o,
    output logic        mul_kill_o,
    input  logic        mul_ready_i,
    output logic [1:0]  count_o
);

    mul_issue_entry_t head;
    logic             push;
    logic             pop;

    // ready depends only on occupancy and kill, never on mul_ready_i
    assign in_ready_o   = (count_o < 2'(DEPTH)) && !kill_i;
    assign in_illegal_o = in_valid_i && in_funct3_i[2];
    assign push         = in_valid_i && in_ready_o && !in_funct3_i[2];
    assign pop          = mul_valid_o && mul_ready_i && !halt_i && !kill_i;

    cv32e40x_mul_issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (kill_i),
        .push  (push),
        .pop   (pop),
        .wdata (mul_decode(in_funct3_i, in_op_a_i, in_op_b_i)),
        .rdata (head),
        .count (count_o)
    );

    assign mul_valid_o       = (count_o != 2'd0);
    assign mul_operator_o    = head.operator;
    assign mul_signed_mode_o = head.signed_mode;
    assign mul_op_a_o        = head.op_a;
    assign mul_op_b_o        = head.op_b;
    assign mul_halt_o        = halt_i;
    assign mul_kill_o        = kill_i;

endmodule

// File: doc/cv32e40x_mul_issue.md
Name: cv32e40x_mul_issue

Overview:
Issue stage directly upstream of the EX-stage multiplier. Accepts decoded multiply instructions from ID over a valid/ready handshake and decodes funct3 into the multiplier operator and signed mode. Holds operands stable in a small FIFO for the full multi-cycle MULH sequence. Presents the head entry to the multiplier and passes halt/kill through to it.

Parameters:
DEPTH, 2, number of buffered instructions; legal values 1 or 2.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid_i  input  1  ID presents a multiply instruction
in_ready_o  output  1  block can accept an entry this cycle
in_funct3_i  input  3  RV32M funct3
in_op_a_i  input  32  rs1 value
in_op_b_i  input  32  rs2 value
in_illegal_o  output  1  funct3[2]=1 presented; entry dropped
halt_i  input  1  pipeline halt
kill_i  input  1  pipeline flush
mul_valid_o  output  1  head entry valid towards multiplier
mul_operator_o  output  mul_opcode_e  MUL_M32 or MUL_H
mul_signed_mode_o  output  2  bit0: op_a signed; bit1: op_b signed
mul_op_a_o  output  32  head operand A
mul_op_b_o  output  32  head operand B
mul_halt_o  output  1  halt to multiplier
mul_kill_o  output  1  kill to multiplier
mul_ready_i  input  1  multiplier ready/done for head entry
count_o  output  2  occupied entries (0..DEPTH)

Behaviour:
- Clocking and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: FIFO empty; count_o=0; mul_valid_o=0; mul_op_a_o/mul_op_b_o=0; mul_operator_o=MUL_M32; mul_signed_mode_o=00; in_ready_o=1.
- Decode, applied at push:
  - 000 MUL: MUL_M32, 00.
  - 001 MULH: MUL_H, 11.
  - 010 MULHSU: MUL_H, 01.
  - 011 MULHU: MUL_H, 00.
  - funct3[2]=1: no push; in_illegal_o = in_valid_i && funct3[2] (combinational); in_ready_o is unaffected.
- Push: in_valid_i && in_ready_o && !funct3[2] && !kill_i. The entry is written at the tail on the rising edge.
- in_ready_o = (count < DEPTH) && !kill_i. There is no combinational path from mul_ready_i to in_ready_o, so a full FIFO cannot accept in the same cycle it pops.
- Pop: mul_valid_o && mul_ready_i && !halt_i && !kill_i. The head advances on the edge.
- mul_valid_o = (count != 0). Head fields are driven from storage, never from inputs (registered outputs).
- Latency: a pushed entry is visible on mul_* the cycle after push. Zero-bubble throughput: pop and push in the same cycle keep count constant when not full.
- Operand stability: head fields stay constant until pop, including across all four MUL_H states and any halt cycles.
- Halt: mul_halt_o = halt_i. No pop while halted. Pushes still allowed if not full.
- Kill:
  - mul_kill_o = kill_i.
  - On the edge with kill_i=1, the FIFO empties: count=0, mul_valid_o=0 next cycle.
  - A push in the same cycle is suppressed. Kill overrides push, pop and halt.
- Storage: circular FIFO with pointers modulo DEPTH; pointer wrap at DEPTH-1 -> 0. For DEPTH=1 the pointers are constant 0.
- Simultaneous push+pop when count=1: new entry becomes head; count stays 1.
- Reset mid-operation: immediate return to reset values; the multiplier sees mul_valid_o=0.

Decomposition:
- mul_opcode_e (MUL_M32, MUL_H) is in cv32e40x_pkg.
- Add to cv32e40x_pkg: typedef mul_issue_entry_t {operator, signed_mode[1:0], op_a[31:0], op_b[31:0]}, and constants FUNCT3_MUL/MULH/MULHSU/MULHU.
- One natural sub-module: cv32e40x_mul_issue_fifo. Generic DEPTH-entry FIFO of mul_issue_entry_t with flush; reused later for the divider issue path.

Test Plan:
1. Push funct3=000, a=0x0000_0003, b=0x0000_0005, mul_ready_i=1 -> next cycle mul_valid_o=1, MUL_M32, mode 00; popped that cycle; count returns 0.
2. Push funct3=001, a=0xFFFF_FFFF, b=0x8000_0000; mul_ready_i low 3 cycles then high -> MUL_H, mode 11, operands constant all 4 cycles, single pop.
3. mul_ready_i=0, push two entries (DEPTH=2) -> count_o=2, in_ready_o=0. Third push is ignored. After one pop, in_ready_o=1 next cycle and order is preserved.
4. count=2, halt_i=1 with mul_ready_i=1 for 5 cycles -> no pop, mul_halt_o=1. Release -> pops resume in order.
5. count=2 plus in_valid_i, assert kill_i one cycle -> next cycle count_o=0, mul_valid_o=0, no push, mul_kill_o=1 that cycle.
6. in_valid_i with funct3=101 -> in_illegal_o=1, count unchanged. Then funct3=010, a=0x8000_0000 -> mode 01, MUL_H.
